// File: rtl/fp_writeback_arbiter.sv
// ============================================================================
// fp_writeback_arbiter : FPU / FP-load writeback arbiter, pending-write
//                        scoreboard and fflags accumulation feed.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_writeback_arbiter #(
  parameter int FLEN      = 32,
  parameter int NUM_FREGS = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_fpu_valid,
  output logic                 o_fpu_ready,
  input  logic [4:0]           i_fpu_rd,
  input  logic [FLEN-1:0]      i_fpu_data,
  input  logic [4:0]           i_fpu_fflags,
  input  logic                 i_lsu_valid,
  output logic                 o_lsu_ready,
  input  logic [4:0]           i_lsu_rd,
  input  logic [FLEN-1:0]      i_lsu_data,
  input  logic                 i_alloc_valid,
  input  logic [4:0]           i_alloc_rd,
  output logic                 o_alloc_busy,
  input  logic                 i_flush,
  input  logic [4:0]           i_rs1,
  input  logic [4:0]           i_rs2,
  input  logic [4:0]           i_rs3,
  output logic                 o_rs1_busy,
  output logic                 o_rs2_busy,
  output logic                 o_rs3_busy,
  output logic [4:0]           o_rd,
  output logic [FLEN-1:0]      o_rd_din,
  output logic                 o_reg_write,
  output logic                 o_fflags_valid,
  output logic [4:0]           o_fflags,
  output logic [NUM_FREGS-1:0] o_pending
);

  typedef enum logic {
    SRC_FPU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  src_e                 rr_q;
  logic                 reg_write_q;
  logic [4:0]           rd_q;
  logic [FLEN-1:0]      din_q;
  logic                 fflags_valid_q;
  logic [4:0]           fflags_q;
  logic [NUM_FREGS-1:0] pending_q;
  logic [NUM_FREGS-1:0] pending_d;

  logic w_fpu_fire;
  logic w_lsu_fire;
  logic w_contended;

  // Readiness ignores the source's own valid; reset forces both low.
  assign o_fpu_ready = !i_rst && (!i_lsu_valid || (rr_q == SRC_FPU));
  assign o_lsu_ready = !i_rst && (!i_fpu_valid || (rr_q == SRC_LSU));

  assign w_fpu_fire  = i_fpu_valid && o_fpu_ready;
  assign w_lsu_fire  = i_lsu_valid && o_lsu_ready;
  assign w_contended = i_fpu_valid && i_lsu_valid;

  // Clear from the committing write first so a same-rd alloc wins.
  always_comb begin
    pending_d = i_flush ? '0 : pending_q;
    if (reg_write_q) begin
      pending_d[rd_q] = 1'b0;
    end
    if (i_alloc_valid) begin
      pending_d[i_alloc_rd] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_q           <= SRC_FPU;
      reg_write_q    <= 1'b0;
      rd_q           <= 5'd0;
      din_q          <= '0;
      fflags_valid_q <= 1'b0;
      fflags_q       <= 5'd0;
      pending_q      <= '0;
    end else begin
      if (w_contended) begin
        rr_q <= (rr_q == SRC_FPU) ? SRC_LSU : SRC_FPU;
      end
      reg_write_q    <= w_fpu_fire || w_lsu_fire;
      fflags_valid_q <= w_fpu_fire;
      fflags_q       <= w_fpu_fire ? i_fpu_fflags : 5'd0;
      if (w_fpu_fire) begin
        rd_q  <= i_fpu_rd;
        din_q <= i_fpu_data;
      end else if (w_lsu_fire) begin
        rd_q  <= i_lsu_rd;
        din_q <= i_lsu_data;
      end
      pending_q <= pending_d;
    end
  end

  // The register file forwards its write port, so the committing rd is readable now.
  assign o_rs1_busy   = pending_q[i_rs1]      && !(reg_write_q && (rd_q == i_rs1));
  assign o_rs2_busy   = pending_q[i_rs2]      && !(reg_write_q && (rd_q == i_rs2));
  assign o_rs3_busy   = pending_q[i_rs3]      && !(reg_write_q && (rd_q == i_rs3));
  assign o_alloc_busy = pending_q[i_alloc_rd] && !(reg_write_q && (rd_q == i_alloc_rd));

  assign o_rd           = rd_q;
  assign o_rd_din       = din_q;
  assign o_reg_write    = reg_write_q;
  assign o_fflags_valid = fflags_valid_q;
  assign o_fflags       = fflags_q;
  assign o_pending      = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_writeback_arbiter.sv
// ============================================================================
// tb_fp_writeback_arbiter : directed + random bench against a reference model.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_writeback_arbiter;

  localparam int FLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            fpu_valid, fpu_ready, lsu_valid, lsu_ready;
  logic [4:0]      fpu_rd, fpu_fflags, lsu_rd, alloc_rd, rs1, rs2, rs3;
  logic [FLEN-1:0] fpu_data, lsu_data;
  logic            alloc_valid, alloc_busy, flush;
  logic            rs1_busy, rs2_busy, rs3_busy;
  logic [4:0]      o_rd, o_fflags;
  logic [FLEN-1:0] o_rd_din;
  logic            o_reg_write, o_fflags_valid;
  logic [31:0]     o_pending;

  always #5 clk = ~clk;

  fp_writeback_arbiter #(.FLEN(FLEN), .NUM_FREGS(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_fpu_valid(fpu_valid), .o_fpu_ready(fpu_ready), .i_fpu_rd(fpu_rd),
    .i_fpu_data(fpu_data), .i_fpu_fflags(fpu_fflags),
    .i_lsu_valid(lsu_valid), .o_lsu_ready(lsu_ready), .i_lsu_rd(lsu_rd),
    .i_lsu_data(lsu_data),
    .i_alloc_valid(alloc_valid), .i_alloc_rd(alloc_rd), .o_alloc_busy(alloc_busy),
    .i_flush(flush), .i_rs1(rs1), .i_rs2(rs2), .i_rs3(rs3),
    .o_rs1_busy(rs1_busy), .o_rs2_busy(rs2_busy), .o_rs3_busy(rs3_busy),
    .o_rd(o_rd), .o_rd_din(o_rd_din), .o_reg_write(o_reg_write),
    .o_fflags_valid(o_fflags_valid), .o_fflags(o_fflags), .o_pending(o_pending)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: favoured source on the next contention, the write being
  // committed this cycle, and the set of registers awaiting a write.
  int              m_favour;       // 0 = FPU, 1 = LSU
  bit              m_wr;
  bit [4:0]        m_rd;
  bit [FLEN-1:0]   m_din;
  bit              m_ffv;
  bit [4:0]        m_ff;
  bit              m_pend [32];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_busy(input bit [4:0] r);
    return m_pend[r] && !(m_wr && m_rd == r);
  endfunction

  task automatic check_all();
    bit [31:0] pv;
    for (int i = 0; i < 32; i++) pv[i] = m_pend[i];
    chk("fpu_ready", fpu_ready, (!rst && (!lsu_valid || m_favour == 0)) ? 1 : 0);
    chk("lsu_ready", lsu_ready, (!rst && (!fpu_valid || m_favour == 1)) ? 1 : 0);
    chk("reg_write", o_reg_write, m_wr);
    chk("rd", o_rd, m_rd);
    chk("rd_din", o_rd_din, m_din);
    chk("fflags_valid", o_fflags_valid, m_ffv);
    if (m_wr) chk("fflags", o_fflags, m_ff);
    chk("pending", o_pending, pv);
    chk("rs1_busy", rs1_busy, exp_busy(rs1));
    chk("rs2_busy", rs2_busy, exp_busy(rs2));
    chk("rs3_busy", rs3_busy, exp_busy(rs3));
    chk("alloc_busy", alloc_busy, exp_busy(alloc_rd));
  endtask

  task automatic model_step();
    bit fpu_go, lsu_go;
    if (rst) begin
      m_favour = 0; m_wr = 0; m_rd = 0; m_din = 0; m_ffv = 0; m_ff = 0;
      for (int i = 0; i < 32; i++) m_pend[i] = 0;
      return;
    end
    if (fpu_valid && lsu_valid) begin
      fpu_go   = (m_favour == 0);
      lsu_go   = !fpu_go;
      m_favour = fpu_go ? 1 : 0;
    end else begin
      fpu_go = fpu_valid;
      lsu_go = lsu_valid;
    end
    if (flush) for (int i = 0; i < 32; i++) m_pend[i] = 0;
    if (m_wr) m_pend[m_rd] = 0;
    if (alloc_valid) m_pend[alloc_rd] = 1;
    m_wr  = fpu_go || lsu_go;
    m_ffv = fpu_go;
    m_ff  = fpu_go ? fpu_fflags : 5'd0;
    if (fpu_go) begin
      m_rd = fpu_rd; m_din = fpu_data;
    end else if (lsu_go) begin
      m_rd = lsu_rd; m_din = lsu_data;
    end
  endtask

  task automatic next();
    @(negedge clk);
    rst = 0; fpu_valid = 0; fpu_rd = 0; fpu_data = 0; fpu_fflags = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0; alloc_valid = 0; alloc_rd = 0;
    flush = 0; rs1 = 0; rs2 = 0; rs3 = 0;
  endtask

  task automatic run();
    #1;
    check_all();
    @(posedge clk);
    model_step();
  endtask

  initial begin
    rst = 1; fpu_valid = 1; lsu_valid = 1; fpu_rd = 0; fpu_data = 0; fpu_fflags = 0;
    lsu_rd = 0; lsu_data = 0; alloc_valid = 0; alloc_rd = 0; flush = 0;
    rs1 = 0; rs2 = 0; rs3 = 0;
    @(posedge clk);
    model_step();

    // reset held with both sources valid
    for (int i = 0; i < 2; i++) begin
      next(); rst = 1; fpu_valid = 1; lsu_valid = 1; fpu_rd = 5'd9; lsu_rd = 5'd10;
      fpu_data = 32'hDEAD0000; lsu_data = 32'hBEEF0000; alloc_valid = 1; alloc_rd = 5'd6;
      run();
    end
    next(); run();
    next(); run();

    // single FPU write
    next(); fpu_valid = 1; fpu_rd = 5'd5; fpu_data = 32'h3F800000; fpu_fflags = 5'h01; run();
    next(); run();
    chk("single_din", o_rd_din, 32'h3F800000);

    // contention
    for (int i = 0; i < 4; i++) begin
      next(); fpu_valid = 1; lsu_valid = 1;
      fpu_rd = 5'(1 + i); lsu_rd = 5'(9 + i);
      fpu_data = 32'h1000 + i; lsu_data = 32'h9000 + i; fpu_fflags = 5'(i);
      run();
    end
    next(); run();

    // scoreboard with bypass
    next(); alloc_valid = 1; alloc_rd = 5'd7; rs2 = 5'd7; run();
    next(); rs2 = 5'd7; run();
    next(); lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 32'h40490FDB; rs2 = 5'd7; run();
    next(); rs2 = 5'd7; run();
    next(); rs2 = 5'd7; run();

    // set/clear collision
    next(); fpu_valid = 1; fpu_rd = 5'd3; fpu_data = 32'h33; run();
    next(); alloc_valid = 1; alloc_rd = 5'd3; run();
    next(); rs1 = 5'd3; run();

    // flush with in-flight write
    next(); flush = 1; run();
    for (int r = 4; r < 8; r++) begin
      next(); alloc_valid = 1; alloc_rd = 5'(r); run();
    end
    next(); fpu_valid = 1; fpu_rd = 5'd4; fpu_data = 32'h44; rs1 = 5'd4; run();
    next(); flush = 1; alloc_valid = 1; alloc_rd = 5'd2; run();
    next(); run();
    chk("flush_pending", o_pending, 32'h00000004);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      next();
      rst         = ($urandom_range(0, 199) == 0);
      flush       = ($urandom_range(0, 39) == 0);
      fpu_valid   = ($urandom_range(0, 9) < 6);
      lsu_valid   = ($urandom_range(0, 9) < 6);
      fpu_rd      = 5'($urandom);
      lsu_rd      = 5'($urandom);
      fpu_data    = $urandom;
      lsu_data    = $urandom;
      fpu_fflags  = 5'($urandom);
      alloc_valid = ($urandom_range(0, 9) < 4);
      alloc_rd    = 5'($urandom);
      rs1         = 5'($urandom);
      rs2         = 5'($urandom);
      rs3         = 5'($urandom);
      run();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
